// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back port arbiter and its result queue.
package wb_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Queue entry layout at default widths: {valid, addr, data}
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result queue: DEPTH entries, per-entry valid bits,
// parallel address-match kill and address-compare ports for hazard checks.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] cmp_a,
  input  logic [ADDR_W-1:0] cmp_b,
  output logic              full,
  output logic              empty,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              hit_a,
  output logic              hit_b
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [PW:0]                   cnt_q, cnt_d;
  logic [DEPTH-1:0]              vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q;
  logic [DEPTH-1:0]              kill_m, hit_am, hit_bm;

  // Per-entry comparators, all entries in parallel
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign kill_m[i] = kill_en && (addr_q[i] == kill_addr);
    assign hit_am[i] = vld_q[i] && (addr_q[i] == cmp_a);
    assign hit_bm[i] = vld_q[i] && (addr_q[i] == cmp_b);
  end

  assign full       = (cnt_q == (PW+1)'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign head_valid = !empty && vld_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign hit_a      = |hit_am;
  assign hit_b      = |hit_bm;

  // Next state: kill first, then pop clears the head slot, then push fills the tail
  always_comb begin
    vld_d  = vld_q & ~kill_m;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = push_valid;
      tail_d        = tail_q + PW'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Payload storage, written on push only
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and a
// long-latency unit. Queued long-latency results drain into idle WB slots;
// a head that keeps losing raises stall_req. Optional same-cycle bypass
// is enabled by defining WB_BYPASS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_write_reg,
  input  logic [DATA_W-1:0] lu_data,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              pending_hit,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic              f_full, f_empty, h_vld, hit_a, hit_b;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic              stall, gnt_q, gnt_p, byp, pop, push, push_valid;
  logic              kill_en, kill_head, wb_nz, lu_nz;
  logic [AGW-1:0]    age_q, age_d;

  wb_result_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_valid (push_valid),
    .push_addr  (lu_write_reg),
    .push_data  (lu_data),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_addr  (wb_write_reg),
    .cmp_a      (id_rs),
    .cmp_b      (id_rt),
    .full       (f_full),
    .empty      (f_empty),
    .head_valid (h_vld),
    .head_addr  (h_addr),
    .head_data  (h_data),
    .hit_a      (hit_a),
    .hit_b      (hit_b)
  );

  // Grant, queue control and output muxing
  always_comb begin
    wb_nz = (wb_write_reg != RZ);
    lu_nz = (lu_write_reg != RZ);
`ifdef WB_BYPASS_EN
    byp   = lu_valid && f_empty && !wb_regwrite && lu_nz;
`else
    byp   = 1'b0;
`endif
    stall     = h_vld && (age_q >= AGW'(STARVE_LIMIT)) && wb_regwrite;
    gnt_q     = stall || (!wb_regwrite && h_vld);
    gnt_p     = wb_regwrite && !stall;
    // a killed (invalid) head leaves silently, one per cycle
    pop       = !f_empty && (gnt_q || !h_vld);
    kill_en   = gnt_p && wb_nz;
    kill_head = kill_en && h_vld && (h_addr == wb_write_reg);
    push      = !rst && lu_valid && !f_full && !byp;
    // reg-0 results and results overwritten by this cycle's pipeline write land invalid
    push_valid = lu_nz && !(kill_en && (lu_write_reg == wb_write_reg));

    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    lu_ready    = 1'b0;
    stall_req   = 1'b0;
    pending_hit = 1'b0;
    if (!rst) begin
      lu_ready    = !f_full;
      stall_req   = stall;
      pending_hit = ((id_rs != RZ) && hit_a) || ((id_rt != RZ) && hit_b);
      if (gnt_q) begin
        rf_we = (h_addr != RZ);
        rf_wa = h_addr;
        rf_wd = h_data;
      end else if (gnt_p) begin
        rf_we = wb_nz;
        rf_wa = wb_write_reg;
        rf_wd = wb_data;
      end else if (byp) begin
        rf_we = 1'b1;
        rf_wa = lu_write_reg;
        rf_wd = lu_data;
      end
    end
  end

  // Age of the current head: counts lost grants, saturating
  always_comb begin
    age_d = age_q;
    if (pop || kill_head || !h_vld)        age_d = '0;
    else if (age_q < AGW'(STARVE_LIMIT))   age_d = age_q + AGW'(1);
  end

  // Age register
  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DATA_W=32, ADDR_W=5, DEPTH=2).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_regwrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_write_reg;
  logic [31:0] lu_data;
  logic [4:0]  id_rs, id_rt;
  logic        pending_hit, stall_req, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_write_reg(lu_write_reg), .lu_data(lu_data),
    .id_rs(id_rs), .id_rt(id_rt), .pending_hit(pending_hit), .stall_req(stall_req),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_regwrite = 0; wb_write_reg = 0; wb_data = 0;
    lu_valid = 0; lu_write_reg = 0; lu_data = 0;
    id_rs = 0; id_rt = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_in();
    cyc();
    wb_regwrite = 1; wb_write_reg = 3; wb_data = 32'h33;
    lu_valid = 1; lu_write_reg = 4; id_rs = 3; id_rt = 4;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, lu_ready, stall_req, pending_hit} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got we=%0b wa=%0d wd=%h rdy=%0b stall=%0b hit=%0b want all 0",
               rf_we, rf_wa, rf_wd, lu_ready, stall_req, pending_hit);
    end
    cyc();
    rst = 0; idle_in();
    #1;
    n_cmp++;
    if ({rf_we, lu_ready, stall_req} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_release got we=%0b rdy=%0b stall=%0b want 0 1 0", rf_we, lu_ready, stall_req);
    end
  endtask

  task automatic test_reset_mid_drain();
    wb_regwrite = 1; wb_write_reg = 9; wb_data = 32'h9;
    lu_valid = 1; lu_write_reg = 5; lu_data = 32'h55;
    cyc();
    lu_write_reg = 6; lu_data = 32'h66;
    #1;
    n_cmp++;
    if (lu_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_drain_second_ready got %0b want 1", lu_ready);
    end
    cyc();
    lu_valid = 0; id_rs = 5; id_rt = 6;
    #1;
    n_cmp++;
    if ({pending_hit, lu_ready} !== 2'b10) begin
      n_err++; $display("FAIL mid_drain_full got hit=%0b rdy=%0b want 1 0", pending_hit, lu_ready);
    end
    rst = 1;
    cyc();
    rst = 0; idle_in(); id_rs = 5; id_rt = 6;
    #1;
    n_cmp++;
    if ({rf_we, lu_ready, pending_hit} !== 3'b010) begin
      n_err++; $display("FAIL mid_drain_after_rst got we=%0b rdy=%0b hit=%0b want 0 1 0",
                        rf_we, lu_ready, pending_hit);
    end
    cyc();
    n_cmp++;
    if ({rf_we, pending_hit} !== 2'b00) begin
      n_err++; $display("FAIL mid_drain_cleared got we=%0b hit=%0b want 0 0", rf_we, pending_hit);
    end
    idle_in();
  endtask

  task automatic test_idle_drain();
    lu_valid = 1; lu_write_reg = 5; lu_data = 32'hAAAA0001;
    #1;
`ifdef WB_BYPASS_EN
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, lu_ready} !== {1'b1, 5'd5, 32'hAAAA0001, 1'b1}) begin
      n_err++; $display("FAIL idle_bypass got we=%0b wa=%0d wd=%h want 1 5 aaaa0001", rf_we, rf_wa, rf_wd);
    end
`else
    n_cmp++;
    if ({rf_we, lu_ready} !== 2'b01) begin
      n_err++; $display("FAIL idle_accept got we=%0b rdy=%0b want 0 1", rf_we, lu_ready);
    end
`endif
    cyc();
    idle_in(); id_rs = 5;
    #1;
`ifdef WB_BYPASS_EN
    n_cmp++;
    if ({rf_we, pending_hit} !== 2'b00) begin
      n_err++; $display("FAIL idle_bypass_not_queued got we=%0b hit=%0b want 0 0", rf_we, pending_hit);
    end
`else
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, pending_hit} !== {1'b1, 5'd5, 32'hAAAA0001, 1'b1}) begin
      n_err++; $display("FAIL idle_drain got we=%0b wa=%0d wd=%h hit=%0b want 1 5 aaaa0001 1",
                        rf_we, rf_wa, rf_wd, pending_hit);
    end
`endif
    cyc();
    n_cmp++;
    if ({rf_we, pending_hit} !== 2'b00) begin
      n_err++; $display("FAIL idle_drain_done got we=%0b hit=%0b want 0 0", rf_we, pending_hit);
    end
    idle_in();
  endtask

  task automatic test_starvation();
    logic [31:0] d;
    wb_regwrite = 1; wb_write_reg = 3; wb_data = 32'h300;
    lu_valid = 1; lu_write_reg = 8; lu_data = 32'h800;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h300}) begin
      n_err++; $display("FAIL starve_push_cycle got we=%0b wa=%0d wd=%h want 1 3 300", rf_we, rf_wa, rf_wd);
    end
    cyc();
    lu_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      d = (k == 6) ? 32'h305 : 32'h300 + 32'(k);
      wb_data = d;
      #1;
      n_cmp++;
      if (k == 5) begin
        if ({stall_req, rf_we, rf_wa, rf_wd} !== {1'b1, 1'b1, 5'd8, 32'h800}) begin
          n_err++; $display("FAIL starve_cycle5 got stall=%0b we=%0b wa=%0d wd=%h want 1 1 8 800",
                            stall_req, rf_we, rf_wa, rf_wd);
        end
      end else begin
        if ({stall_req, rf_we, rf_wa, rf_wd} !== {1'b0, 1'b1, 5'd3, d}) begin
          n_err++; $display("FAIL starve_cycle%0d got stall=%0b we=%0b wa=%0d wd=%h want 0 1 3 %h",
                            k, stall_req, rf_we, rf_wa, rf_wd, d);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (dut.age_q !== '0) begin
          n_err++; $display("FAIL starve_age_clear got %0d want 0", dut.age_q);
        end
      end
      cyc();
    end
    idle_in();
  endtask

  task automatic test_full();
    wb_regwrite = 1; wb_write_reg = 10; wb_data = 32'hA1;
    lu_valid = 1; lu_write_reg = 11; lu_data = 32'hB1;
    cyc();
    wb_data = 32'hA2; lu_write_reg = 12; lu_data = 32'hB2;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_wa, rf_wd} !== {1'b1, 1'b1, 5'd10, 32'hA2}) begin
      n_err++; $display("FAIL full_second got rdy=%0b wa=%0d wd=%h want 1 10 a2", lu_ready, rf_wa, rf_wd);
    end
    cyc();
    wb_data = 32'hA3; lu_write_reg = 13; lu_data = 32'hB3;
    #1;
    n_cmp++;
    if ({lu_ready, stall_req} !== 2'b00) begin
      n_err++; $display("FAIL full_ready_low got rdy=%0b stall=%0b want 0 0", lu_ready, stall_req);
    end
    cyc();
    wb_regwrite = 0;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_wa, rf_wd} !== {1'b0, 1'b1, 5'd11, 32'hB1}) begin
      n_err++; $display("FAIL full_pop_no_push got rdy=%0b wa=%0d wd=%h want 0 11 b1", lu_ready, rf_wa, rf_wd);
    end
    cyc();
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_wa, rf_wd} !== {1'b1, 1'b1, 5'd12, 32'hB2}) begin
      n_err++; $display("FAIL full_third_accept got rdy=%0b wa=%0d wd=%h want 1 12 b2", lu_ready, rf_wa, rf_wd);
    end
    cyc();
    lu_valid = 0;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd13, 32'hB3}) begin
      n_err++; $display("FAIL full_third_drain got we=%0b wa=%0d wd=%h want 1 13 b3", rf_we, rf_wa, rf_wd);
    end
    cyc();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL full_empty got we=%0b want 0", rf_we);
    end
    idle_in();
  endtask

  task automatic test_waw_kill();
    wb_regwrite = 1; wb_write_reg = 9; wb_data = 32'h99;
    lu_valid = 1; lu_write_reg = 7; lu_data = 32'h11;
    cyc();
    lu_valid = 0; wb_write_reg = 7; wb_data = 32'h22; id_rs = 7;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, pending_hit} !== {1'b1, 5'd7, 32'h22, 1'b1}) begin
      n_err++; $display("FAIL waw_pipe_write got we=%0b wa=%0d wd=%h hit=%0b want 1 7 22 1",
                        rf_we, rf_wa, rf_wd, pending_hit);
    end
    cyc();
    wb_regwrite = 0;
    #1;
    n_cmp++;
    if ({rf_we, pending_hit} !== 2'b00) begin
      n_err++; $display("FAIL waw_killed got we=%0b hit=%0b wd=%h want 0 0", rf_we, pending_hit, rf_wd);
    end
    cyc();
    n_cmp++;
    if ({rf_we, lu_ready} !== 2'b01) begin
      n_err++; $display("FAIL waw_after got we=%0b rdy=%0b want 0 1", rf_we, lu_ready);
    end
    wb_regwrite = 1; wb_write_reg = 4; wb_data = 32'h44;
    lu_valid = 1; lu_write_reg = 4; lu_data = 32'h55; id_rs = 0;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd4, 32'h44}) begin
      n_err++; $display("FAIL waw_same_cycle got we=%0b wa=%0d wd=%h want 1 4 44", rf_we, rf_wa, rf_wd);
    end
    cyc();
    idle_in(); id_rs = 4;
    #1;
    n_cmp++;
    if ({rf_we, pending_hit} !== 2'b00) begin
      n_err++; $display("FAIL waw_same_cycle_invalid got we=%0b hit=%0b wd=%h want 0 0", rf_we, pending_hit, rf_wd);
    end
    cyc();
    idle_in();
  endtask

  task automatic test_reg0();
    lu_valid = 1; lu_write_reg = 0; lu_data = 32'hDEAD;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we} !== 2'b10) begin
      n_err++; $display("FAIL reg0_accept got rdy=%0b we=%0b want 1 0", lu_ready, rf_we);
    end
    cyc();
    id_rs = 0; id_rt = 0;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, pending_hit} !== 3'b100) begin
      n_err++; $display("FAIL reg0_queued got rdy=%0b we=%0b hit=%0b want 1 0 0", lu_ready, rf_we, pending_hit);
    end
    cyc();
    lu_valid = 0;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we} !== 2'b10) begin
      n_err++; $display("FAIL reg0_drain got rdy=%0b we=%0b want 1 0", lu_ready, rf_we);
    end
    cyc();
    wb_regwrite = 1; wb_write_reg = 0; wb_data = 32'hBEEF;
    #1;
    n_cmp++;
    if ({rf_we, lu_ready} !== 2'b01) begin
      n_err++; $display("FAIL reg0_pipe got we=%0b rdy=%0b want 0 1", rf_we, lu_ready);
    end
    cyc();
    idle_in();
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_idle_drain();
    test_starvation();
    test_full();
    test_waw_kill();
    test_reg0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
